result_bram_drain_ctrl: RTL and testbench

Sequences host/DMA readout of the 8192-entry FP16 circular result buffer that the result writer fills in 256-bit BRAM lines. It accepts a drain command for N results, fetches lines from rd_ptr onward, and unpacks the FP16s onto a valid/ready stream. It owns and advances the read pointer that the writer uses for its occupancy and backpressure calculation.

---
 rtl/result_bram_drain_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_result_bram_drain_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bram_drain_ctrl.sv
// Drains FP16 results from the circular result BRAM onto a valid/ready stream.
// Owns the read pointer the writer uses for occupancy and backpressure.
module result_bram_drain_ctrl #(
    parameter int RD_LATENCY = 1,
    parameter int CAPACITY   = 8192
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [13:0]  i_cmd_count,
    input  logic [13:0]  i_used_entries,
    input  logic         i_write_top_reset,
    output logic [8:0]   o_bram_rd_addr,
    output logic         o_bram_rd_en,
    input  logic [255:0] i_bram_rd_data,
    output logic [15:0]  o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [12:0]  o_rd_ptr,
    output logic [13:0]  o_remaining,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_abort
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        LAT,
        STREAM,
        DONE
    } state_t;

    localparam logic [2:0]  LAT_LAST = 3'(RD_LATENCY);
    localparam logic [12:0] PTR_LAST = 13'(CAPACITY - 1);

    state_t         state_q;
    state_t         state_d;
    logic [12:0]    rd_ptr;
    logic [12:0]    ptr_inc;
    logic [13:0]    remaining;
    logic [4:0]     avail;
    logic [2:0]     lat_cnt;
    logic [255:0]   line_buf;
    logic [15:0]    out_data;
    logic           out_valid;
    logic           zero_done;
    logic           abort_q;
    logic           handshake;
    logic [4:0]     room;
    logic [4:0]     used_sat;
    logic [4:0]     rem_sat;
    logic [4:0]     min_a;
    logic [4:0]     snap_avail;

    assign handshake = out_valid && i_out_ready;
    assign ptr_inc   = (rd_ptr == PTR_LAST) ? 13'd0 : rd_ptr + 13'd1;

    // Entries we may emit from this fetch: up to the line end, never past the writer.
    always_comb begin
        room       = 5'd16 - {1'b0, rd_ptr[3:0]};
        used_sat   = (i_used_entries > 14'd16) ? 5'd16 : i_used_entries[4:0];
        rem_sat    = (remaining > 14'd16) ? 5'd16 : remaining[4:0];
        min_a      = (room < used_sat) ? room : used_sat;
        snap_avail = (min_a < rem_sat) ? min_a : rem_sat;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid && (i_cmd_count != 14'd0)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_used_entries != 14'd0) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = (snap_avail != 5'd0) ? LAT : WAIT;
            end
            LAT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (remaining == 14'd1) begin
                        state_d = DONE;
                    end else if (avail == 5'd1) begin
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (i_write_top_reset) begin
            state_d = IDLE;
        end
    end

    // Host buffer reset overrides every other datapath update.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr    <= 13'd0;
            remaining <= 14'd0;
            avail     <= 5'd0;
            lat_cnt   <= 3'd0;
            line_buf  <= '0;
            out_data  <= 16'd0;
            out_valid <= 1'b0;
            zero_done <= 1'b0;
            abort_q   <= 1'b0;
        end else if (i_write_top_reset) begin
            rd_ptr    <= 13'd0;
            remaining <= 14'd0;
            avail     <= 5'd0;
            out_valid <= 1'b0;
            zero_done <= 1'b0;
            abort_q   <= (state_q != IDLE);
        end else begin
            abort_q   <= 1'b0;
            zero_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        remaining <= i_cmd_count;
                        zero_done <= (i_cmd_count == 14'd0);
                    end
                end
                FETCH: begin
                    avail   <= snap_avail;
                    lat_cnt <= 3'd1;
                end
                LAT: begin
                    if (lat_cnt == LAT_LAST) begin
                        line_buf  <= i_bram_rd_data;
                        out_data  <= i_bram_rd_data[{rd_ptr[3:0], 4'b0000} +: 16];
                        out_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        rd_ptr    <= ptr_inc;
                        remaining <= remaining - 14'd1;
                        avail     <= avail - 5'd1;
                        if ((remaining == 14'd1) || (avail == 5'd1)) begin
                            out_valid <= 1'b0;
                        end else begin
                            out_data <= line_buf[{ptr_inc[3:0], 4'b0000} +: 16];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cmd_ready    = (state_q == IDLE);
    assign o_busy         = (state_q != IDLE);
    assign o_bram_rd_en   = (state_q == FETCH);
    assign o_bram_rd_addr = rd_ptr[12:4];
    assign o_done         = (state_q == DONE) || zero_done;
    assign o_abort        = abort_q;
    assign o_out_data     = out_data;
    assign o_out_valid    = out_valid;
    assign o_rd_ptr       = rd_ptr;
    assign o_remaining    = remaining;

endmodule

// File: tb/tb_result_bram_drain_ctrl.sv
// Directed bench for result_bram_drain_ctrl with a BRAM/writer model and stream scoreboard.
module tb_result_bram_drain_ctrl;

    localparam int LAT = 2;

    logic         i_clk;
    logic         i_reset_n;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [13:0]  i_cmd_count;
    logic [13:0]  i_used_entries;
    logic         i_write_top_reset;
    logic [8:0]   o_bram_rd_addr;
    logic         o_bram_rd_en;
    logic [255:0] i_bram_rd_data;
    logic [15:0]  o_out_data;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [12:0]  o_rd_ptr;
    logic [13:0]  o_remaining;
    logic         o_busy;
    logic         o_done;
    logic         o_abort;

    logic [255:0] mem [0:511];
    logic [255:0] rd_pipe [0:LAT-1];
    logic [12:0]  wr_ptr;
    logic [15:0]  wr_val;
    logic [15:0]  exp_q[$];
    logic [8:0]   fetch_q[$];
    int           vectors;
    int           miscompares;
    int           hs_count;
    int           done_count;
    int           abort_count;
    logic         prev_stall;
    logic         prev_wtr;
    logic [15:0]  prev_data;

    result_bram_drain_ctrl #(.RD_LATENCY(LAT), .CAPACITY(8192)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_cmd_count       (i_cmd_count),
        .i_used_entries    (i_used_entries),
        .i_write_top_reset (i_write_top_reset),
        .o_bram_rd_addr    (o_bram_rd_addr),
        .o_bram_rd_en      (o_bram_rd_en),
        .i_bram_rd_data    (i_bram_rd_data),
        .o_out_data        (o_out_data),
        .o_out_valid       (o_out_valid),
        .i_out_ready       (i_out_ready),
        .o_rd_ptr          (o_rd_ptr),
        .o_remaining       (o_remaining),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_abort           (o_abort)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_used_entries = {1'b0, wr_ptr - o_rd_ptr};
    assign i_bram_rd_data = rd_pipe[LAT-1];

    // BRAM model: data only appears for a real read pulse, garbage otherwise.
    always @(posedge i_clk) begin
        rd_pipe[0] <= o_bram_rd_en ? mem[o_bram_rd_addr] : {16{16'hDEAD}};
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream scoreboard, stall stability and event counters, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_done) done_count++;
            if (o_abort) abort_count++;
            if (o_bram_rd_en) fetch_q.push_back(o_bram_rd_addr);
            if (prev_stall && !prev_wtr) begin
                checkOutput("stall_valid", 32'(o_out_valid), 32'd1);
                checkOutput("stall_data", 32'(o_out_data), 32'(prev_data));
            end
            if (o_out_valid && i_out_ready && !i_write_top_reset) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 32'd1, 32'd0);
                end else begin
                    checkOutput("out_data", 32'(o_out_data), 32'(exp_q.pop_front()));
                end
                hs_count++;
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_wtr   = i_write_top_reset;
            prev_data  = o_out_data;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic writeEntries(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[12:4]][{wr_ptr[3:0], 4'b0000} +: 16] = wr_val;
            exp_q.push_back(wr_val);
            wr_val = wr_val + 16'd1;
            wr_ptr = wr_ptr + 13'd1;
        end
    endtask

    task automatic applyStimulus(input int count);
        i_cmd_valid = 1'b1;
        i_cmd_count = 14'(count);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic hostReset(input logic exp_abort);
        i_write_top_reset = 1'b1;
        wr_ptr = 13'd0;
        exp_q.delete();
        tick();
        i_write_top_reset = 1'b0;
        checkOutput("host_reset_abort", 32'(o_abort), 32'(exp_abort));
        checkOutput("host_reset_rd_ptr", 32'(o_rd_ptr), 32'd0);
    endtask

    task automatic waitDone(input int budget, input string tag);
        int start;
        int cyc;
        start = done_count;
        cyc = 0;
        while (done_count == start && cyc < budget) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done_count != start), 32'd1);
        tick(3);
        checkOutput({tag, "_done_pulses"}, 32'(done_count - start), 32'd1);
        checkOutput({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hs0;
        int d0;
        int a0;
        int cyc;
        vectors = 0;
        miscompares = 0;
        hs_count = 0;
        done_count = 0;
        abort_count = 0;
        prev_stall = 1'b0;
        prev_wtr = 1'b0;
        prev_data = 16'd0;
        wr_ptr = 13'd0;
        wr_val = 16'd0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        i_cmd_valid = 1'b0;
        i_cmd_count = 14'd0;
        i_write_top_reset = 1'b0;
        i_out_ready = 1'b1;
        i_reset_n = 1'b1;
        #1 i_reset_n = 1'b0;
        #2;
        checkOutput("rst_rd_ptr", 32'(o_rd_ptr), 32'd0);
        checkOutput("rst_remaining", 32'(o_remaining), 32'd0);
        checkOutput("rst_addr", 32'(o_bram_rd_addr), 32'd0);
        checkOutput("rst_out_data", 32'(o_out_data), 32'd0);
        checkOutput("rst_rd_en", 32'(o_bram_rd_en), 32'd0);
        checkOutput("rst_valid", 32'(o_out_valid), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_abort", 32'(o_abort), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        tick(2);
        i_reset_n = 1'b1;
        tick();

        $display("[TB] zero-count command");
        fetch_q.delete();
        d0 = done_count;
        applyStimulus(0);
        checkOutput("zero_done_high", 32'(o_done), 32'd1);
        checkOutput("zero_busy", 32'(o_busy), 32'd0);
        checkOutput("zero_cmd_ready", 32'(o_cmd_ready), 32'd1);
        tick();
        checkOutput("zero_done_low", 32'(o_done), 32'd0);
        checkOutput("zero_done_count", 32'(done_count - d0), 32'd1);
        checkOutput("zero_no_fetch", 32'(fetch_q.size()), 32'd0);
        checkOutput("zero_rd_ptr", 32'(o_rd_ptr), 32'd0);

        $display("[TB] 40-entry drain");
        fetch_q.delete();
        hs0 = hs_count;
        writeEntries(40);
        applyStimulus(40);
        waitDone(400, "t1");
        checkOutput("t1_outputs", 32'(hs_count - hs0), 32'd40);
        checkOutput("t1_q_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t1_fetches", 32'(fetch_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_fetch_addr", 32'((fetch_q.size() > i) ? fetch_q[i] : 9'h1FF), 32'(i));
        end
        checkOutput("t1_rd_ptr", 32'(o_rd_ptr), 32'd40);
        checkOutput("t1_remaining", 32'(o_remaining), 32'd0);

        $display("[TB] drain starting empty");
        hostReset(1'b0);
        fetch_q.delete();
        hs0 = hs_count;
        applyStimulus(5);
        tick(10);
        checkOutput("t2_wait_busy", 32'(o_busy), 32'd1);
        checkOutput("t2_wait_nofetch", 32'(fetch_q.size()), 32'd0);
        checkOutput("t2_wait_valid", 32'(o_out_valid), 32'd0);
        writeEntries(3);
        cyc = 0;
        while ((hs_count - hs0) < 3 && cyc < 50) begin
            tick();
            cyc++;
        end
        tick(12);
        checkOutput("t2_first3", 32'(hs_count - hs0), 32'd3);
        checkOutput("t2_mid_fetches", 32'(fetch_q.size()), 32'd1);
        checkOutput("t2_mid_valid", 32'(o_out_valid), 32'd0);
        checkOutput("t2_mid_busy", 32'(o_busy), 32'd1);
        checkOutput("t2_mid_rd_ptr", 32'(o_rd_ptr), 32'd3);
        checkOutput("t2_mid_remaining", 32'(o_remaining), 32'd2);
        writeEntries(2);
        waitDone(100, "t2");
        checkOutput("t2_fetches", 32'(fetch_q.size()), 32'd2);
        checkOutput("t2_refetch_addr", 32'((fetch_q.size() > 1) ? fetch_q[1] : 9'h1FF), 32'd0);
        checkOutput("t2_rd_ptr", 32'(o_rd_ptr), 32'd5);
        checkOutput("t2_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] pointer wrap");
        hostReset(1'b0);
        writeEntries(8190);
        applyStimulus(8190);
        waitDone(20000, "t3_pre");
        checkOutput("t3_pre_rd_ptr", 32'(o_rd_ptr), 32'd8190);
        fetch_q.delete();
        hs0 = hs_count;
        writeEntries(4);
        applyStimulus(4);
        waitDone(100, "t3");
        checkOutput("t3_outputs", 32'(hs_count - hs0), 32'd4);
        checkOutput("t3_fetches", 32'(fetch_q.size()), 32'd2);
        checkOutput("t3_fetch_511", 32'((fetch_q.size() > 0) ? fetch_q[0] : 9'h0AA), 32'd511);
        checkOutput("t3_fetch_0", 32'((fetch_q.size() > 1) ? fetch_q[1] : 9'h0AA), 32'd0);
        checkOutput("t3_rd_ptr", 32'(o_rd_ptr), 32'd2);
        checkOutput("t3_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] random ready backpressure");
        hs0 = hs_count;
        d0 = done_count;
        writeEntries(100);
        applyStimulus(100);
        cyc = 0;
        while (done_count == d0 && cyc < 3000) begin
            i_out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        i_out_ready = 1'b1;
        checkOutput("t4_done_seen", 32'(done_count != d0), 32'd1);
        checkOutput("t4_cycles_ge_100", 32'(cyc >= 100), 32'd1);
        checkOutput("t4_outputs", 32'(hs_count - hs0), 32'd100);
        checkOutput("t4_q_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t4_rd_ptr", 32'(o_rd_ptr), 32'd102);

        $display("[TB] abort mid-stream");
        hostReset(1'b0);
        writeEntries(20);
        hs0 = hs_count;
        d0 = done_count;
        a0 = abort_count;
        applyStimulus(20);
        cyc = 0;
        while ((hs_count - hs0) < 7 && cyc < 100) begin
            tick();
            cyc++;
        end
        checkOutput("t5_pre_valid", 32'(o_out_valid), 32'd1);
        i_out_ready = 1'b0;
        hostReset(1'b1);
        checkOutput("t5_remaining", 32'(o_remaining), 32'd0);
        checkOutput("t5_valid", 32'(o_out_valid), 32'd0);
        checkOutput("t5_busy", 32'(o_busy), 32'd0);
        checkOutput("t5_cmd_ready", 32'(o_cmd_ready), 32'd1);
        tick();
        checkOutput("t5_abort_low", 32'(o_abort), 32'd0);
        checkOutput("t5_abort_count", 32'(abort_count - a0), 32'd1);
        checkOutput("t5_no_done", 32'(done_count - d0), 32'd0);
        checkOutput("t5_outputs", 32'(hs_count - hs0), 32'd7);
        i_out_ready = 1'b1;
        hs0 = hs_count;
        writeEntries(3);
        applyStimulus(3);
        waitDone(100, "t5_after");
        checkOutput("t5_after_outputs", 32'(hs_count - hs0), 32'd3);
        checkOutput("t5_after_rd_ptr", 32'(o_rd_ptr), 32'd3);
        checkOutput("t5_after_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
